// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns PC and IR and fetches words over a req/ack memory handshake.
// It applies branch, jump and jump-register PC updates while idle.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    output logic        fetch_done,
    output logic        busy,
    output logic        IM_req,
    output logic [31:0] IM_addr,
    input  logic        IM_ack,
    input  logic [31:0] IM_rdata,
    input  logic        PC_ld,
    input  logic [1:0]  PC_sel,
    input  logic [31:0] PC_jr,
    output logic [31:0] PC_out,
    output logic [31:0] IR_out,
    output logic [31:0] SE_16,
    output logic        align_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        align_q, align_d;
    logic        im_req_q, im_req_d;
    logic [31:0] se16;

    assign se16 = {{16{ir_q[15]}}, ir_q[15:0]};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        align_d  = align_q;
        case (state_q)
            IDLE: begin
                // The PC update lands on the same edge that accepts a fetch,
                // so a simultaneous fetch reads from the updated PC.
                if (PC_ld) begin
                    case (PC_sel)
                        2'd0: begin
                            pc_d = {PC_jr[31:2], 2'b00};
                            if (PC_jr[1:0] != 2'b00) begin
                                align_d = 1'b1;
                            end
                        end
                        2'd1:    pc_d = pc_q + {se16[29:0], 2'b00};
                        2'd2:    pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                        default: pc_d = pc_q;
                    endcase
                end
                if (fetch_start) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (IM_ack) begin
                    ir_d    = IM_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        im_req_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= 32'h0;
            align_q  <= 1'b0;
            im_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            align_q  <= align_d;
            im_req_q <= im_req_d;
        end
    end

    assign fetch_done = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign IM_req     = im_req_q;
    assign IM_addr    = pc_q;
    assign PC_out     = pc_q;
    assign IR_out     = ir_q;
    assign SE_16      = se16;
    assign align_err  = align_q;

endmodule
